// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Top-level sequencer for the matrix multiplier. Bytes from the UART
// receiver are steered into the A operand memory, then the B operand
// memory (N*N elements each). The multiply core is then started and
// awaited. After that, MEM_to_TX is enabled until it reports the last
// result byte, and the block returns to loading A.
//
// Handshakes: rx_valid is a one-cycle strobe with no ready/back-pressure.
// Every strobe seen in LOAD_A/LOAD_B is written exactly one cycle later.
// A strobe seen in any other state is dropped and sets the sticky overrun
// flag. mul_done is only honoured in MUL_WAIT and tx_done only in TX. At
// any other time they are ignored, whether they are pulses or levels.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   rx_valid    byte strobe from the UART receiver
//   rx_data     received byte, valid with rx_valid
//   a_we        A operand memory write enable (one cycle per byte)
//   b_we        B operand memory write enable (one cycle per byte)
//   wr_addr     operand memory write address
//   wr_data     operand memory write data
//   mul_start   one-cycle start pulse to the multiply core
//   mul_done    multiply core completion
//   read_R_mat  level enable to MEM_to_TX while the result is being sent
//   tx_done     MEM_to_TX reports the last result byte sent
//   busy        high in MUL_START, MUL_WAIT and TX
//   overrun     sticky: a byte arrived while not loading
//   state       current state encoding, for debug
//
// AW must satisfy 2**AW >= N*N so that every element has an address.
// ---------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          a_we,
    output logic          b_we,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          mul_start,
    input  logic          mul_done,
    output logic          read_R_mat,
    input  logic          tx_done,
    output logic          busy,
    output logic          overrun,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        MUL_START = 3'd2,
        MUL_WAIT  = 3'd3,
        TX        = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);

    state_t        cur_state;
    state_t        nxt_state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic          a_we_nxt;
    logic          b_we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;
    logic          ovr_nxt;
    logic          loading;

    assign loading = (cur_state == LOAD_A) || (cur_state == LOAD_B);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = cnt;
        a_we_nxt  = 1'b0;
        b_we_nxt  = 1'b0;
        addr_nxt  = wr_addr;
        data_nxt  = wr_data;
        ovr_nxt   = overrun;

        // A byte outside the loading states is lost.
        if (rx_valid && !loading) begin
            ovr_nxt = 1'b1;
        end

        case (cur_state)
            LOAD_A, LOAD_B: begin
                if (rx_valid) begin
                    a_we_nxt = (cur_state == LOAD_A);
                    b_we_nxt = (cur_state == LOAD_B);
                    addr_nxt = cnt;
                    data_nxt = rx_data;
                    if (cnt == LAST_IDX) begin
                        // The state moves on in the same cycle that the
                        // last element's write strobe is issued.
                        cnt_nxt   = '0;
                        nxt_state = (cur_state == LOAD_A) ? LOAD_B : MUL_START;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            MUL_START: begin
                // Single cycle. A mul_done seen here is stale and ignored.
                nxt_state = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_done) begin
                    nxt_state = TX;
                end
            end
            TX: begin
                if (tx_done) begin
                    nxt_state = LOAD_A;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                nxt_state = LOAD_A;
                cnt_nxt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs. The strobes and levels are
    // decoded from the next state. This makes them line up exactly with
    // the cycles the FSM spends in the matching state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= LOAD_A;
            cnt        <= '0;
            a_we       <= 1'b0;
            b_we       <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            mul_start  <= 1'b0;
            read_R_mat <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            cnt        <= cnt_nxt;
            a_we       <= a_we_nxt;
            b_we       <= b_we_nxt;
            wr_addr    <= addr_nxt;
            wr_data    <= data_nxt;
            mul_start  <= (nxt_state == MUL_START);
            read_R_mat <= (nxt_state == TX);
            busy       <= (nxt_state == MUL_START) || (nxt_state == MUL_WAIT) ||
                          (nxt_state == TX);
            overrun    <= ovr_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//
// Directed bench for matmul_seq_ctrl (N=3, DW=8, AW=4). A phase-level
// reference model predicts every registered output each cycle. A compare
// thread checks the DUT against that model on every falling edge outside
// reset. The main thread drives directed vectors and also checks literal,
// hand-computed values (addresses, data, states, sticky flag).
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NN = N * N;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          a_we;
  logic          b_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mul_start;
  logic          mul_done;
  logic          read_R_mat;
  logic          tx_done;
  logic          busy;
  logic          overrun;
  logic [2:0]    state;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .a_we       (a_we),
    .b_we       (b_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mul_start  (mul_start),
    .mul_done   (mul_done),
    .read_R_mat (read_R_mat),
    .tx_done    (tx_done),
    .busy       (busy),
    .overrun    (overrun),
    .state      (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 load A, 1 load B, 2 start, 3 wait, 4 transmit.
  int            m_phase;
  int            m_cnt;
  logic          m_a_we;
  logic          m_b_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_ovr;

  function automatic int next_phase(input int ph, input int cnt, input logic rv,
                                    input logic md, input logic td);
    case (ph)
      0, 1:    return (rv && cnt == NN - 1) ? ph + 1 : ph;
      2:       return 3;
      3:       return md ? 4 : 3;
      4:       return td ? 0 : 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_a_we  <= 1'b0;
      m_b_we  <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_ovr   <= 1'b0;
    end else begin
      m_a_we <= (m_phase == 0) && rx_valid;
      m_b_we <= (m_phase == 1) && rx_valid;
      if (m_phase <= 1 && rx_valid) begin
        m_addr <= m_cnt[AW-1:0];
        m_data <= rx_data;
        m_cnt  <= (m_cnt + 1) % NN;
      end
      if (m_phase >= 2 && rx_valid) m_ovr <= 1'b1;
      m_phase <= next_phase(m_phase, m_cnt, rx_valid, mul_done, tx_done);
    end
  end

  // ---------------- write monitor ----------------
  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];
  int            a_wr_cnt = 0;
  int            b_wr_cnt = 0;
  int            start_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) begin
        mem_a[wr_addr] <= wr_data;
        a_wr_cnt       <= a_wr_cnt + 1;
      end
      if (b_we) begin
        mem_b[wr_addr] <= wr_data;
        b_wr_cnt       <= b_wr_cnt + 1;
      end
      if (mul_start) start_cnt <= start_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [DW-1:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_mul_done();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // ---------------- stimulus + compare ----------------
  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    mul_done = 1'b0;
    tx_done  = 1'b0;

    fork
      // Per-cycle compare against the model.
      begin
        forever begin
          @(negedge clk);
          if (!rst) begin
            chk("cyc_a_we", a_we, m_a_we);
            chk("cyc_b_we", b_we, m_b_we);
            chk("cyc_state", state, m_phase);
            chk("cyc_mul_start", mul_start, m_phase == 2);
            chk("cyc_read_R_mat", read_R_mat, m_phase == 4);
            chk("cyc_busy", busy, m_phase >= 2);
            chk("cyc_overrun", overrun, m_ovr);
            chk("cyc_we_exclusive", a_we & b_we, 1'b0);
            if (m_a_we || m_b_we) begin
              chk("cyc_wr_addr", wr_addr, m_addr);
              chk("cyc_wr_data", wr_data, m_data);
            end
          end
        end
      end
      // Directed sequence.
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_a_we", a_we, 1'b0);
        chk("rst_b_we", b_we, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'd0);
        chk("rst_wr_data", wr_data, 8'd0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_read_R_mat", read_R_mat, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        idle(2);

        // Load A with bytes 1..9, one idle cycle between bytes.
        for (int i = 1; i <= NN; i++) begin
          send_byte(8'(i));
          if (i == NN) begin
            chk("a_last_we", a_we, 1'b1);
            chk("a_last_addr", wr_addr, 4'd8);
            chk("a_last_data", wr_data, 8'd9);
            chk("a_done_state", state, 3'd1);
          end
          idle(1);
        end
        for (int k = 0; k < NN; k++) chk("mem_a_load1", mem_a[k], 32'(k + 1));
        chk("a_wr_count", a_wr_cnt, 9);
        chk("b_none_in_a", b_wr_cnt, 0);

        // Load B back-to-back with bytes 10..18.
        for (int i = 10; i <= 18; i++) send_byte(8'(i));
        chk("b_last_we", b_we, 1'b1);
        chk("b_last_addr", wr_addr, 4'd8);
        chk("b_last_data", wr_data, 8'd18);
        chk("start_state", state, 3'd2);
        chk("start_pulse", mul_start, 1'b1);
        chk("start_busy", busy, 1'b1);
        idle(1);
        chk("start_gone", mul_start, 1'b0);
        chk("wait_state", state, 3'd3);
        for (int k = 0; k < NN; k++) chk("mem_b_load1", mem_b[k], 32'(k + 10));
        chk("b_wr_count", b_wr_cnt, 9);

        // Long wait with a stray byte in MUL_WAIT.
        idle(10);
        send_byte(8'hAA);
        chk("stray_no_a_we", a_we, 1'b0);
        chk("stray_no_b_we", b_we, 1'b0);
        chk("stray_overrun", overrun, 1'b1);
        idle(989);
        chk("wait_no_read", read_R_mat, 1'b0);
        chk("wait_state_held", state, 3'd3);
        chk("one_start", start_cnt, 1);
        chk("stray_a_count", a_wr_cnt, 9);
        chk("stray_b_count", b_wr_cnt, 9);
        pulse_mul_done();
        chk("tx_read_rise", read_R_mat, 1'b1);
        chk("tx_state", state, 3'd4);
        idle(5);
        chk("tx_read_held", read_R_mat, 1'b1);
        pulse_tx_done();
        chk("tx_read_fall", read_R_mat, 1'b0);
        chk("back_to_load_a", state, 3'd0);
        chk("idle_busy", busy, 1'b0);
        chk("overrun_sticky1", overrun, 1'b1);

        // Second round; mul_done during MUL_START is ignored.
        for (int i = 0; i < NN; i++) send_byte(8'(8'h30 + i));
        for (int i = 0; i < NN; i++) send_byte(8'(8'h40 + i));
        chk("round2_start", state, 3'd2);
        pulse_mul_done();
        chk("done_in_start_ignored", state, 3'd3);
        chk("overrun_sticky2", overrun, 1'b1);
        for (int k = 0; k < NN; k++) chk("mem_a_load2", mem_a[k], 32'(8'h30 + k));
        for (int k = 0; k < NN; k++) chk("mem_b_load2", mem_b[k], 32'(8'h40 + k));
        pulse_mul_done();
        idle(3);
        chk("tx2_read", read_R_mat, 1'b1);

        // Asynchronous reset in the middle of TX.
        rst = 1'b1;
        #1;
        chk("async_read_drop", read_R_mat, 1'b0);
        chk("async_state", state, 3'd0);
        chk("async_overrun_clr", overrun, 1'b0);
        chk("async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        idle(2);

        // Four bytes, then spurious done pulses, then the rest of A.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i));
        tx_done  = 1'b1;
        mul_done = 1'b1;
        tick();
        tx_done  = 1'b0;
        mul_done = 1'b0;
        chk("spurious_state", state, 3'd0);
        send_byte(8'h25);
        chk("fifth_we", a_we, 1'b1);
        chk("fifth_addr", wr_addr, 4'd4);
        chk("fifth_data", wr_data, 8'h25);
        for (int i = 5; i < NN; i++) send_byte(8'(8'h21 + i));
        chk("load3_state", state, 3'd1);
        idle(1);
        for (int k = 0; k < NN; k++) chk("mem_a_load3", mem_a[k], 32'(8'h21 + k));
        idle(2);
      end
    join_any

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Top-level sequencer for the matrix multiplier.
- Steers bytes arriving from the UART receiver into the A and B operand memories.
- Once both operands are loaded, launches the multiply core and waits for it to finish.
- Then drives read_R_mat into MEM_to_TX until the result matrix has been transmitted, and returns to loading.

Parameters:
- N, 3, matrix dimension; each operand is N*N elements.
- DW, 8, element/byte width.
- AW, 4, operand memory address width; must satisfy 2^AW >= N*N.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rx_valid  input  1  one-cycle pulse per byte received by the UART.
- rx_data  input  DW  received byte; valid when rx_valid=1.
- a_we  output  1  write enable, A operand memory.
- b_we  output  1  write enable, B operand memory.
- wr_addr  output  AW  operand memory write address.
- wr_data  output  DW  operand memory write data.
- mul_start  output  1  one-cycle start pulse to the multiply core.
- mul_done  input  1  multiply core completion pulse (or level; sampled only in MUL_WAIT).
- read_R_mat  output  1  level enable to MEM_to_TX; high while the result matrix is being sent.
- tx_done  input  1  MEM_to_TX reports the last result byte sent (sampled only in TX).
- busy  output  1  high in MUL_START, MUL_WAIT, TX.
- overrun  output  1  sticky flag: an rx_valid arrived outside LOAD_A/LOAD_B.
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset (async, rst=1): state=LOAD_A and element counter=0. All outputs are 0: a_we, b_we, wr_addr, wr_data, mul_start, read_R_mat, busy, overrun.
- All outputs are registered.
- State encoding: LOAD_A=0, LOAD_B=1, MUL_START=2, MUL_WAIT=3, TX=4.
- LOAD_A:
  - rx_valid at cycle t gives a_we=1 for exactly one cycle at t+1, with wr_addr=counter and wr_data=rx_data captured at t.
  - Counter increments at t+1.
  - When the byte with counter=N*N-1 is written, counter wraps to 0 and state goes to LOAD_B in the same cycle that a_we is asserted.
- LOAD_B: identical to LOAD_A but drives b_we. After element N*N-1, state goes to MUL_START.
- MUL_START:
  - mul_start=1 for exactly one cycle, busy=1, then state goes to MUL_WAIT.
  - A mul_done in this cycle is ignored.
- MUL_WAIT:
  - Hold until mul_done=1.
  - On mul_done, go to TX; read_R_mat rises the next cycle.
- TX:
  - read_R_mat=1 and held continuously.
  - On tx_done=1, read_R_mat=0 the next cycle and state goes to LOAD_A with counter=0.
- Byte latency: rx_valid to memory write is 1 cycle. Back-to-back rx_valid on consecutive cycles must be accepted without loss.
- rx_valid in MUL_START, MUL_WAIT or TX: the byte is dropped, no write occurs, overrun is set and stays 1 until rst.
- a_we and b_we are never high simultaneously. mul_start and read_R_mat are never high simultaneously.
- mul_done outside MUL_WAIT and tx_done outside TX are ignored, with no state change.
- Reset mid-operation (e.g. during TX):
  - read_R_mat drops immediately (async).
  - The block restarts at LOAD_A and all partially loaded data is discarded, i.e. counter=0.

Test Plan:
- Reset, then 9 rx_valid pulses with bytes 1..9 (N=3) -> a_we pulses at addr 0..8 with data 1..9, state=LOAD_B after the 9th; b_we never asserted.
- Then 9 back-to-back rx_valid bytes 10..18 -> b_we at addr 0..8 with data 10..18; next cycle mul_start=1 for exactly one cycle; busy=1.
- In MUL_WAIT, hold mul_done=0 for 1000 cycles -> read_R_mat stays 0. Pulse mul_done -> read_R_mat=1 next cycle, held. Pulse tx_done -> read_R_mat=0 next cycle, state=LOAD_A, busy=0.
- Send an rx_valid byte 0xAA during MUL_WAIT -> no a_we/b_we, overrun=1 and stays 1 through the following full load cycle.
- Assert rst for 1 cycle mid-TX with read_R_mat=1 -> read_R_mat=0 asynchronously. Afterwards 9 bytes load into A starting at addr 0.
- Pulse tx_done and mul_done while in LOAD_A after 4 bytes -> no state change; the 5th byte is written at addr 4.
